tape_feeder_tx: RTL

//  Byte-FIFO-fed UART 8N1 transmitter that drives the PDP8e rx pin (keyboard/reader input).

---
 rtl/tape_feeder_tx.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/tape_feeder_tx.sv
// Byte-FIFO-fed 8N1 UART transmitter that streams host bytes onto the PDP8e rx pin,
// with configurable stop bits and an idle gap after every frame.
module tape_feeder_tx #(
  parameter int CLOCK_FREQUENCY = 12_000_000,
  parameter int BAUD_RATE       = 9600,
  parameter int FIFO_AW         = 4,
  parameter int STOP_BITS       = 1,
  parameter int GAP_BITS        = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wr_en,
  input  logic [0:7]  wr_data,
  input  logic        tx_enable,
  output logic        full,
  output logic        empty,
  output logic        overflow,
  output logic        busy,
  output logic [0:15] sent_count,
  output logic        tx
);

  localparam int DIV     = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int DEPTH   = 2 ** FIFO_AW;
  localparam int CNT_W   = ($clog2(STOP_BITS * DIV) < 1) ? 1 : $clog2(STOP_BITS * DIV);
  localparam int BIT_LIM = (GAP_BITS > 8) ? GAP_BITS : 8;
  localparam int BIT_W   = $clog2(BIT_LIM);

  localparam logic [CNT_W-1:0]   BAUD_LAST = CNT_W'(DIV - 1);
  localparam logic [BIT_W-1:0]   DATA_LAST = BIT_W'(7);
  localparam logic [BIT_W-1:0]   STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [BIT_W-1:0]   GAP_LAST  = BIT_W'((GAP_BITS == 0) ? 0 : GAP_BITS - 1);
  localparam logic [FIFO_AW:0]   OCC_FULL  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   OCC_ONE   = (FIFO_AW + 1)'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   occ, occ_n;
  logic               push, pop;

  logic [2:0]         state, state_n;
  logic [CNT_W-1:0]   baud_cnt, baud_n;
  logic [BIT_W-1:0]   bit_idx, bit_n;
  logic [7:0]         shift_reg, shift_n;
  logic [0:15]        sent_n;
  logic               tx_n;
  logic               bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    shift_n = shift_reg;
    sent_n  = sent_count;
    tx_n    = tx;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        tx_n = 1'b1;
        if (tx_enable && !empty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = S_START;
          baud_n  = '0;
          tx_n    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n = S_DATA;
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = shift_reg[0];
        end else begin
          baud_n = baud_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_idx == DATA_LAST) begin
            state_n = S_STOP;
            bit_n   = '0;
            tx_n    = 1'b1;
          end else begin
            bit_n   = bit_idx + BIT_W'(1);
            shift_n = shift_reg >> 1;
            tx_n    = shift_reg[1];
          end
        end else begin
          baud_n = baud_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_idx == STOP_LAST) begin
            sent_n  = sent_count + 16'd1;
            bit_n   = '0;
            state_n = (GAP_BITS == 0) ? S_IDLE : S_GAP;
          end else begin
            bit_n = bit_idx + BIT_W'(1);
          end
        end else begin
          baud_n = baud_cnt + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_idx == GAP_LAST) state_n = S_IDLE;
          else                     bit_n   = bit_idx + BIT_W'(1);
        end else begin
          baud_n = baud_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  // A push at full still lands when the head leaves in the same cycle.
  assign push = wr_en && (!full || pop);

  always_comb begin
    occ_n = occ;
    if (push && !pop)      occ_n = occ + OCC_ONE;
    else if (pop && !push) occ_n = occ - OCC_ONE;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      sent_count <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_n;
      bit_idx    <= bit_n;
      shift_reg  <= shift_n;
      sent_count <= sent_n;
      tx         <= tx_n;
      busy       <= (state_n != S_IDLE);
      occ        <= occ_n;
      full       <= (occ_n == OCC_FULL);
      empty      <= (occ_n == '0);
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      if (wr_en && !push) overflow <= 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; reset clears the pointers, which makes old contents unreachable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule
